pc_ctrl_bpred: RTL
==================

Name: pc_ctrl_bpred

Overview:
- Parametrised next-generation PC control unit for the pipelined core.
- Owns the fetch PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for fetch-stage prediction.
- Resolves B (PC-relative) and BR (register) branches in EX against the 3-bit condition code and the Z/V/N flags.
- Issues redirect/flush on mispredict, handles HALT, and keeps branch and mispredict performance counters.

Parameters:
- PC_W, 16, PC and target width.
- IMM_W, 9, branch immediate width (word offset, sign-extended).
- BTB_DEPTH, 8, BTB entries (power of 2, ≥2); IDX_W = log2(BTB_DEPTH).
- RST_VEC, 16'h0000, PC value after reset.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_f  in  1  hold fetch PC (hazard stall).
- halt_d  in  1  HALT decoded in ID.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_br  in  1  EX instruction is B or BR.
- ex_is_breg  in  1  1 = BR (target = ex_reg_tgt), 0 = B.
- ex_cond  in  3  condition code ccc.
- ex_flags  in  3  {Z,V,N} as [2],[1],[0].
- ex_imm  in  IMM_W  B offset in words.
- ex_reg_tgt  in  PC_W  BR target.
- ex_pc  in  PC_W  PC of the EX branch.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_tgt  in  PC_W  predicted target carried down the pipe.
- pc_f  out  PC_W  current fetch PC.
- pred_taken_f  out  1  fetch prediction for pc_f.
- pred_tgt_f  out  PC_W  predicted target for pc_f.
- flush  out  1  kill IF/ID/EX-younger instructions.
- halted  out  1  core halted.
- br_cnt  out  CNT_W  resolved branches.
- mispred_cnt  out  CNT_W  mispredicted branches.

Behaviour:
- Reset (async, rst_n=0):
  - pc_f=RST_VEC; all BTB valid bits=0 and counters=2'b01; state=RUN; counters=0.
  - Outputs: flush=0, halted=0, pred_taken_f=0, pred_tgt_f=0.
- Conditions (taken):
  - 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 Z=1|N=1; 110 V=1; 111 always.
- Resolution (combinational, when ex_valid&ex_is_br):
  - B target = ex_pc+2+(sext(ex_imm)<<1), mod 2^PC_W; BR target = ex_reg_tgt.
  - mispredict = taken≠ex_pred_taken, or (taken & ex_pred_taken & target≠ex_pred_tgt).
  - flush = mispredict, same cycle, combinational.
- Fetch lookup (combinational):
  - idx = pc_f[IDX_W:1]; tag = pc_f[PC_W-1:IDX_W+1].
  - hit = valid & tag match; pred_taken_f = hit & ctr[1]; pred_tgt_f = hit ? entry target : 0.
- Next-PC priority, evaluated each rising edge:
  1. mispredict: pc_f ← taken ? target : ex_pc+2.
  2. state HALTED, or halt_d in RUN: pc_f holds.
  3. stall_f: pc_f holds.
  4. pred_taken_f: pc_f ← pred_tgt_f.
  5. otherwise pc_f ← pc_f+2, wrapping at 2^PC_W.
- BTB update (every resolved branch, ignoring stall):
  - Taken, hit: counter +1 saturating at 11; target rewritten.
  - Taken, miss: allocate/overwrite entry (valid=1, tag, target, counter=10).
  - Not taken, hit: counter −1 saturating at 00.
  - Not taken, miss: no change.
  - The update is visible to the next-cycle lookup; same-cycle lookup sees old contents.
- State machine:
  - RUN→HALTED when halt_d=1 and no mispredict that cycle.
  - If halt_d and mispredict coincide: redirect wins; the HALT is wrong-path and state stays RUN.
  - HALTED is sticky until reset; halted=1 is registered, so it asserts the cycle after entry.
  - In HALTED: no BTB updates, no counter increments, flush=0.
- Counters:
  - br_cnt increments per resolved branch; mispred_cnt increments per mispredict.
  - Both saturate at all-ones.
- Reset mid-operation: asynchronous return to reset values; in-flight resolution is discarded.

Test Plan:
- Reset with RST_VEC=0, no stall: pc_f = 0,2,4,6 on successive cycles; pred_taken_f=0; flush=0.
- Cold BTB, B at ex_pc=0x0010, ccc=111, imm=9'h1FE, ex_pred_taken=0 → flush=1 that cycle; next pc_f=0x000E; mispred_cnt=1; refetch of 0x0010 → pred_taken_f=1, pred_tgt_f=0x000E.
- Condition sweep: every ccc against all 8 flag combinations, e.g. ccc=010 with Z=0,N=0 → taken; ccc=100 with Z=0,N=1 → not taken. Check flush against ex_pred_taken.
- Counter saturation: four taken resolves of the same branch → counter=11; three not-taken → 00 and pred_taken_f=0; a further not-taken leaves it at 00.
- stall_f=1 for 3 cycles while pc_f=0x0020 → pc_f holds; a mispredict during the stall still redirects.
- halt_d=1 with no mispredict → pc_f frozen, halted=1 the next cycle and sticky. halt_d=1 with a coincident mispredict → redirect taken, halted stays 0. rst_n low mid-run → pc_f=RST_VEC immediately.

Source files
------------

// File: rtl/pc_ctrl_bpred.sv
// Fetch PC control with a direct-mapped BTB (2-bit counters), EX-stage branch
// resolution, mispredict flush, HALT handling and branch performance counters.
//
// state      | meaning
// ST_RUN     | normal fetch, predict and resolve
// ST_HALTED  | HALT taken; PC frozen, no updates, sticky until reset
module pc_ctrl_bpred #(
    parameter int              PC_W      = 16,
    parameter int              IMM_W     = 9,
    parameter int              BTB_DEPTH = 8,
    parameter logic [PC_W-1:0] RST_VEC   = '0,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_f,
    input  logic             halt_d,
    input  logic             ex_valid,
    input  logic             ex_is_br,
    input  logic             ex_is_breg,
    input  logic [2:0]       ex_cond,
    input  logic [2:0]       ex_flags,
    input  logic [IMM_W-1:0] ex_imm,
    input  logic [PC_W-1:0]  ex_reg_tgt,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic [PC_W-1:0]  ex_pred_tgt,
    output logic [PC_W-1:0]  pc_f,
    output logic             pred_taken_f,
    output logic [PC_W-1:0]  pred_tgt_f,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 1;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t                 state_q, state_d;
    logic                   halted_q, halted_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [CNT_W-1:0]       br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]       mis_cnt_q, mis_cnt_d;

    logic [BTB_DEPTH-1:0]   btb_vld_q, btb_vld_d;
    logic [TAG_W-1:0]       btb_tag_q [BTB_DEPTH];
    logic [TAG_W-1:0]       btb_tag_d [BTB_DEPTH];
    logic [PC_W-1:0]        btb_tgt_q [BTB_DEPTH];
    logic [PC_W-1:0]        btb_tgt_d [BTB_DEPTH];
    logic [1:0]             btb_ctr_q [BTB_DEPTH];
    logic [1:0]             btb_ctr_d [BTB_DEPTH];

    logic [IDX_W-1:0]       f_idx, e_idx;
    logic [TAG_W-1:0]       f_tag, e_tag;
    logic                   f_hit, e_hit;
    logic                   res_v, taken, mispredict;
    logic                   flag_z, flag_v, flag_n;
    logic [PC_W-1:0]        imm_ext, b_tgt, res_tgt, seq_pc;

    assign f_idx = pc_q[IDX_W:1];
    assign f_tag = pc_q[PC_W-1:IDX_W+1];
    assign f_hit = btb_vld_q[f_idx] && (btb_tag_q[f_idx] == f_tag);

    assign e_idx = ex_pc[IDX_W:1];
    assign e_tag = ex_pc[PC_W-1:IDX_W+1];
    assign e_hit = btb_vld_q[e_idx] && (btb_tag_q[e_idx] == e_tag);

    assign {flag_z, flag_v, flag_n} = ex_flags;

    always_comb begin
        taken = 1'b0;
        case (ex_cond)
            3'b000: taken = !flag_z;
            3'b001: taken = flag_z;
            3'b010: taken = !flag_z && !flag_n;
            3'b011: taken = flag_n;
            3'b100: taken = flag_z || (!flag_z && !flag_n);
            3'b101: taken = flag_z || flag_n;
            3'b110: taken = flag_v;
            3'b111: taken = 1'b1;
        endcase
    end

    // Branches reaching EX after HALT are wrong-path; nothing resolves while halted.
    assign res_v   = ex_valid && ex_is_br && (state_q == ST_RUN);
    assign imm_ext = {{(PC_W-IMM_W){ex_imm[IMM_W-1]}}, ex_imm};
    assign seq_pc  = ex_pc + PC_W'(2);
    assign b_tgt   = seq_pc + {imm_ext[PC_W-2:0], 1'b0};
    assign res_tgt = ex_is_breg ? ex_reg_tgt : b_tgt;

    assign mispredict = res_v && ((taken != ex_pred_taken) ||
                                  (taken && ex_pred_taken && (res_tgt != ex_pred_tgt)));

    always_comb begin
        btb_vld_d = btb_vld_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        btb_ctr_d = btb_ctr_q;
        if (res_v) begin
            if (taken) begin
                if (e_hit) begin
                    if (btb_ctr_q[e_idx] != 2'b11) btb_ctr_d[e_idx] = btb_ctr_q[e_idx] + 2'd1;
                    btb_tgt_d[e_idx] = res_tgt;
                end else begin
                    btb_vld_d[e_idx] = 1'b1;
                    btb_tag_d[e_idx] = e_tag;
                    btb_tgt_d[e_idx] = res_tgt;
                    btb_ctr_d[e_idx] = 2'b10;
                end
            end else if (e_hit && (btb_ctr_q[e_idx] != 2'b00)) begin
                btb_ctr_d[e_idx] = btb_ctr_q[e_idx] - 2'd1;
            end
        end
    end

    always_comb begin
        pc_d      = pc_q + PC_W'(2);
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        state_d   = state_q;
        if (mispredict)                              pc_d = taken ? res_tgt : seq_pc;
        else if ((state_q == ST_HALTED) || halt_d)   pc_d = pc_q;
        else if (stall_f)                            pc_d = pc_q;
        else if (pred_taken_f)                       pc_d = pred_tgt_f;
        if (res_v && (br_cnt_q != '1))       br_cnt_d  = br_cnt_q + CNT_W'(1);
        if (mispredict && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
        if ((state_q == ST_RUN) && halt_d && !mispredict) state_d = ST_HALTED;
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RST_VEC;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
            btb_vld_q <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
                btb_ctr_q[i] <= 2'b01;
            end
        end else begin
            pc_q      <= pc_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            btb_vld_q <= btb_vld_d;
            btb_tag_q <= btb_tag_d;
            btb_tgt_q <= btb_tgt_d;
            btb_ctr_q <= btb_ctr_d;
        end
    end

    assign pc_f         = pc_q;
    assign pred_taken_f = f_hit && btb_ctr_q[f_idx][1];
    assign pred_tgt_f   = f_hit ? btb_tgt_q[f_idx] : '0;
    assign flush        = mispredict;
    assign halted       = halted_q;
    assign br_cnt       = br_cnt_q;
    assign mispred_cnt  = mis_cnt_q;

endmodule
